// File: rtl/lsu_pack.sv
// lsu_pack: load/store narrowing unit between the MEM stage and a word-wide bus.
// Stores are packed into byte/halfword lanes with byte enables; loads have the
// addressed lane extracted and sign/zero-extended. A req/ack bus handshake with
// wait states, alignment checking and an optional bus timeout is provided.
module lsu_pack #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    // pipeline request side
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_sign_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    // pipeline response side
    output logic        resp_valid_o,
    output logic        resp_err_o,
    output logic [31:0] resp_rdata_o,
    // word-wide data bus
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_byteen_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Wait counter just wide enough to hold TIMEOUT; it stops at all-ones.
    localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Counter value seen on the last waiting edge before giving up.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [1:0]         size_q;
    logic               sign_q;
    logic [1:0]         off_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [31:0]        resp_rdata_q;
    logic               bus_req_q;
    logic               bus_we_q;
    logic [31:0]        bus_addr_q;
    logic [3:0]         bus_byteen_q;
    logic [31:0]        bus_wdata_q;

    // Request decode: lane enables, replicated store data, alignment error.
    logic               req_bad;
    logic [3:0]         lane_en;
    logic [31:0]        pack_wdata;

    // Load path: lane picked from the returned word, then extended.
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic [31:0]        ld_data;

    logic               accept;
    logic               timed_out;

    assign accept    = req_valid_i && (state_q == IDLE);
    assign timed_out = TO_EN && (cnt_q == TO_LAST);

    // Decode the incoming request into bus lanes and an alignment verdict.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
        req_bad    = 1'b0;
        lane_en    = 4'b0000;
        pack_wdata = 32'h0;
        case (req_size_i)
            SZ_BYTE: begin
                lane_en    = 4'b0001 << req_addr_i[1:0];
                pack_wdata = {4{req_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                lane_en    = req_addr_i[1] ? 4'b1100 : 4'b0011;
                pack_wdata = {2{req_wdata_i[15:0]}};
                req_bad    = req_addr_i[0];
            end
            SZ_WORD: begin
                lane_en    = 4'b1111;
                pack_wdata = req_wdata_i;
                req_bad    = |req_addr_i[1:0];
            end
            default: begin
                req_bad    = 1'b1;
            end
        endcase
    end

    // Select the addressed lane of the read word and extend it to 32 bits.
    always_comb begin
        ld_byte = bus_rdata_i[7:0];
        case (off_q)
            2'd1:    ld_byte = bus_rdata_i[15:8];
            2'd2:    ld_byte = bus_rdata_i[23:16];
            2'd3:    ld_byte = bus_rdata_i[31:24];
            default: ld_byte = bus_rdata_i[7:0];
        endcase
        ld_half = off_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (size_q)
            SZ_BYTE: ld_data = {{24{sign_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{sign_q & ld_half[15]}}, ld_half};
            default: ld_data = bus_rdata_i;
        endcase
    end

    // Transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            size_q       <= SZ_BYTE;
            sign_q       <= 1'b0;
            off_q        <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= 32'h0;
            bus_byteen_q <= 4'b0000;
            bus_wdata_q  <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        size_q <= req_size_i;
                        sign_q <= req_sign_i;
                        off_q  <= req_addr_i[1:0];
                        if (req_bad) begin
                            // Rejected before touching the bus.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q      <= BUS;
                            cnt_q        <= '0;
                            bus_req_q    <= 1'b1;
                            bus_we_q     <= req_we_i;
                            bus_addr_q   <= {req_addr_i[31:2], 2'b00};
                            bus_byteen_q <= lane_en;
                            bus_wdata_q  <= req_we_i ? pack_wdata : 32'h0;
                        end
                    end
                end
                BUS: begin
                    if (bus_ack_i) begin
                        // Ack beats a timeout on the same edge.
                        state_q      <= RESP;
                        bus_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= bus_we_q ? 32'h0 : ld_data;
                    end else if (timed_out) begin
                        state_q      <= RESP;
                        bus_req_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 32'h0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                    bus_req_q    <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == IDLE);
    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;
    assign bus_req_o    = bus_req_q;
    assign bus_we_o     = bus_we_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_byteen_o = bus_byteen_q;
    assign bus_wdata_o  = bus_wdata_q;

endmodule

// File: tb/tb_lsu_pack.sv
// Directed bench for lsu_pack with a short timeout so the timeout path is reachable.
module tb_lsu_pack;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_byteen;

    int total = 0;
    int bad   = 0;

    lsu_pack #(.TIMEOUT(4)) dut (
        .clk_i       (clk),
        .reset_ni    (reset_n),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_size_i  (req_size),
        .req_sign_i  (req_sign),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .resp_valid_o(resp_valid),
        .resp_err_o  (resp_err),
        .resp_rdata_o(resp_rdata),
        .bus_req_o   (bus_req),
        .bus_we_o    (bus_we),
        .bus_addr_o  (bus_addr),
        .bus_byteen_o(bus_byteen),
        .bus_wdata_o (bus_wdata),
        .bus_ack_i   (bus_ack),
        .bus_rdata_i (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns in the cycle after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic sign,
                         input logic [31:0] addr, input logic [31:0] wdata);
        check("ready_before_req", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    int n_req;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_size  = 2'b00;
        req_sign  = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 32'h0;
        #2;
        check("rst_ready",      {31'b0, req_ready},  32'd1);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_err",   {31'b0, resp_err},   32'd0);
        check("rst_rdata",      resp_rdata,          32'h0);
        check("rst_bus_req",    {31'b0, bus_req},    32'd0);
        check("rst_bus_addr",   bus_addr,            32'h0);
        check("rst_byteen",     {28'b0, bus_byteen}, 32'h0);
        check("rst_bus_wdata",  bus_wdata,           32'h0);
        tick();
        reset_n = 1'b1;
        tick();

        // Store byte at 0x1003, ack in first bus cycle.
        issue(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h1234_56AB);
        check("sb_bus_req",   {31'b0, bus_req},    32'd1);
        check("sb_bus_we",    {31'b0, bus_we},     32'd1);
        check("sb_bus_addr",  bus_addr,            32'h0000_1000);
        check("sb_byteen",    {28'b0, bus_byteen}, 32'h8);
        check("sb_wdata",     bus_wdata,           32'hABAB_ABAB);
        check("sb_ready_busy", {31'b0, req_ready}, 32'd0);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("sb_resp_valid", {31'b0, resp_valid}, 32'd1);
        check("sb_resp_err",   {31'b0, resp_err},   32'd0);
        check("sb_resp_rdata", resp_rdata,          32'h0);
        check("sb_bus_req_off", {31'b0, bus_req},   32'd0);
        tick();
        check("sb_pulse_end", {31'b0, resp_valid}, 32'd0);

        // Load half signed at 0x2002, ack after 3 wait cycles (also the timeout edge).
        issue(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'hFFFF_FFFF);
        check("lh_byteen", {28'b0, bus_byteen}, 32'hC);
        check("lh_wdata",  bus_wdata,           32'h0);
        check("lh_we",     {31'b0, bus_we},     32'd0);
        tick(); tick(); tick();
        check("lh_wait_req",   {31'b0, bus_req},    32'd1);
        check("lh_wait_valid", {31'b0, resp_valid}, 32'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h8001_FFFF;
        tick();
        bus_ack   = 1'b0;
        check("lhs_valid", {31'b0, resp_valid}, 32'd1);
        check("lhs_err",   {31'b0, resp_err},   32'd0);
        check("lhs_rdata", resp_rdata,          32'hFFFF_8001);
        tick();
        check("lhs_hold", resp_rdata, 32'hFFFF_8001);

        // Same, zero-extended.
        issue(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0);
        tick(); tick(); tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("lhu_valid", {31'b0, resp_valid}, 32'd1);
        check("lhu_rdata", resp_rdata,          32'h0000_8001);
        tick();

        // Load byte unsigned at 0x0001.
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0001, 32'h0);
        check("lbu_byteen", {28'b0, bus_byteen}, 32'h2);
        bus_ack   = 1'b1;
        bus_rdata = 32'h0000_F000;
        tick();
        bus_ack   = 1'b0;
        check("lbu_rdata", resp_rdata, 32'h0000_00F0);
        tick();

        // Load byte signed, lane 3.
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0);
        bus_ack   = 1'b1;
        bus_rdata = 32'h9A00_0000;
        tick();
        bus_ack   = 1'b0;
        check("lb3_rdata", resp_rdata, 32'hFFFF_FF9A);
        tick();

        // Load word at 0x4 passes through unchanged.
        issue(1'b0, 2'b10, 1'b1, 32'h0000_0004, 32'h0);
        check("lw_addr",   bus_addr,            32'h0000_0004);
        check("lw_byteen", {28'b0, bus_byteen}, 32'hF);
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_ack   = 1'b0;
        check("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
        tick();

        // Store half upper lane.
        issue(1'b1, 2'b01, 1'b0, 32'h0000_00F2, 32'hCAFE_1234);
        check("sh_byteen", {28'b0, bus_byteen}, 32'hC);
        check("sh_wdata",  bus_wdata,           32'h1234_1234);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check("sh_rdata", resp_rdata, 32'h0);
        tick();

        // Misaligned word store at 0x6: error in the next cycle, no bus cycle.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0006, 32'h5555_5555);
        check("mis_valid",   {31'b0, resp_valid}, 32'd1);
        check("mis_err",     {31'b0, resp_err},   32'd1);
        check("mis_bus_req", {31'b0, bus_req},    32'd0);
        check("mis_rdata",   resp_rdata,          32'h0);
        tick();
        check("mis_end", {31'b0, resp_valid}, 32'd0);
        check("mis_err_hold", {31'b0, resp_err}, 32'd1);

        // Illegal size.
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
        check("ill_valid",   {31'b0, resp_valid}, 32'd1);
        check("ill_err",     {31'b0, resp_err},   32'd1);
        check("ill_bus_req", {31'b0, bus_req},    32'd0);
        tick();

        // Misaligned halfword.
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0003, 32'h0);
        check("mish_err",     {31'b0, resp_err}, 32'd1);
        check("mish_bus_req", {31'b0, bus_req},  32'd0);
        tick();

        // Timeout: no ack, bus_req should be high for exactly 4 cycles.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        n_req = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_req) n_req++;
            if (resp_valid) break;
            tick();
        end
        check("to_req_cycles", n_req,                32'd4);
        check("to_valid",      {31'b0, resp_valid},  32'd1);
        check("to_err",        {31'b0, resp_err},    32'd1);
        check("to_rdata",      resp_rdata,           32'h0);
        tick();

        // Ack on the 4th bus cycle wins over the timeout.
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        tick(); tick(); tick();
        bus_ack   = 1'b1;
        bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_ack   = 1'b0;
        check("to4_valid", {31'b0, resp_valid}, 32'd1);
        check("to4_err",   {31'b0, resp_err},   32'd0);
        check("to4_rdata", resp_rdata,          32'h0BAD_F00D);
        tick();

        // Reset while in BUS: outputs clear immediately, no response afterwards.
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h7777_7777);
        check("rb_in_bus", {31'b0, bus_req}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rb_bus_req",   {31'b0, bus_req},    32'd0);
        check("rb_ready",     {31'b0, req_ready},  32'd1);
        check("rb_bus_wdata", bus_wdata,           32'h0);
        check("rb_valid",     {31'b0, resp_valid}, 32'd0);
        tick();
        reset_n = 1'b1;
        // Stray ack in IDLE must not create a response.
        bus_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_valid", {31'b0, resp_valid}, 32'd0);
            check("stray_ready", {31'b0, req_ready},  32'd1);
        end
        bus_ack = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
